// File: rtl/apb_master_bridge_pkg.sv
// Shared types and constants for the APB requester bridge.
package apb_master_pkg;

  localparam int APB_ADDR_WIDTH = 32;
  localparam int APB_DATA_WIDTH = 32;

  localparam int CMD_ADDR_W = APB_ADDR_WIDTH;
  localparam int CMD_DATA_W = APB_DATA_WIDTH;

  // Bridge transfer phases.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Bit positions inside PPROT.
  localparam int PROT_PRIV   = 0;
  localparam int PROT_NONSEC = 1;
  localparam int PROT_INSTR  = 2;

  // One host-side command as carried into the bridge.
  typedef struct packed {
    logic                    write;
    logic [CMD_ADDR_W-1:0]   addr;
    logic [CMD_DATA_W-1:0]   wdata;
    logic [CMD_DATA_W/8-1:0] strb;
    logic [2:0]              prot;
  } apb_cmd_t;

  // Assemble a PPROT value from its three attribute bits.
  function automatic logic [2:0] make_prot(input logic priv, input logic nonsec,
                                           input logic instr);
    logic [2:0] p;
    p              = '0;
    p[PROT_PRIV]   = priv;
    p[PROT_NONSEC] = nonsec;
    p[PROT_INSTR]  = instr;
    return p;
  endfunction

endpackage

// File: rtl/apb_master_bridge_timeout_counter.sv
// Saturating ACCESS-phase wait counter; flags the last permitted wait cycle.
module apb_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW    = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int LIMIT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);
  localparam logic [CW-1:0] CMAX    = '1;

  logic [CW-1:0] count;

  // Count stalled ACCESS cycles; saturate instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rstn || clear) begin
      count <= '0;
    end else if (enable && (count != CMAX)) begin
      count <= count + CW'(1);
    end
  end

  // A zero limit disables the abort entirely.
  assign expired = (TIMEOUT_CYCLES != 0) && (count == LIMIT_C);

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: one valid/ready command -> one SETUP/ACCESS transfer -> one response.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_error,
  output logic                    rsp_timeout,
  output logic                    sel,
  output logic                    enable,
  output logic                    write,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] strb,
  output logic [2:0]              prot,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    ready,
  input  logic                    slave_error
);

  apb_state_e state, next_state;
  logic       handshake;
  logic       expired;
  logic       tmo_clear;
  logic       tmo_enable;

  assign cmd_ready  = rstn && (state == IDLE);
  assign handshake  = cmd_valid && cmd_ready;
  assign tmo_clear  = (state == SETUP);
  assign tmo_enable = (state == ACCESS) && !ready;

  apb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .expired(expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode; a completing slave wins over a simultaneous timeout.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (handshake) next_state = SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (ready || expired) next_state = RESP;
      RESP:    if (rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Registered APB and response outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sel         <= 1'b0;
      enable      <= 1'b0;
      write       <= 1'b0;
      addr        <= '0;
      wdata       <= '0;
      strb        <= '0;
      prot        <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      sel       <= (next_state == SETUP) || (next_state == ACCESS);
      enable    <= (next_state == ACCESS);
      rsp_valid <= (next_state == RESP);
      if (handshake) begin
        write <= cmd_write;
        addr  <= cmd_addr;
        wdata <= cmd_wdata;
        strb  <= cmd_write ? cmd_strb : '0;
        prot  <= cmd_prot;
      end
      if (state == ACCESS) begin
        if (ready) begin
          rsp_rdata   <= write ? '0 : rdata;
          rsp_error   <= slave_error;
          rsp_timeout <= 1'b0;
        end else if (expired) begin
          rsp_rdata   <= '0;
          rsp_error   <= 1'b1;
          rsp_timeout <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: directed table, hand-written corner sequences, random traffic.
module tb_apb_master_bridge;
  import apb_master_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic [2:0]  cmd_prot = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        sel, enable, write;
  logic [31:0] addr, wdata;
  logic [3:0]  strb;
  logic [2:0]  prot;
  logic [31:0] rdata = '0;
  logic        ready = 1'b0;
  logic        slave_error = 1'b0;

  always #5 clk = ~clk;

  apb_master_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .sel(sel), .enable(enable), .write(write), .addr(addr), .wdata(wdata),
    .strb(strb), .prot(prot), .rdata(rdata), .ready(ready), .slave_error(slave_error)
  );

  int total = 0;
  int bad   = 0;
  int last_wait;

  typedef struct {
    bit        wr;
    bit [31:0] a;
    bit [31:0] wd;
    bit [3:0]  st;
    bit [2:0]  pr;
    int        waits;
    bit        err;
    bit [31:0] srd;
    int        delay;
    bit [31:0] e_rdata;
    bit        e_err;
    bit        e_to;
    int        e_en;
  } vec_t;

  vec_t vecs[7];

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Run one transfer; called just after a falling edge, returns just after a falling edge.
  task automatic do_txn(input bit wr, input bit [31:0] a, input bit [31:0] wd,
                        input bit [3:0] st, input bit [2:0] pr, input int waits,
                        input bit err, input bit [31:0] srd, input int delay,
                        input bit [31:0] e_rdata, input bit e_err, input bit e_to,
                        input int e_en);
    logic [71:0] exp_bus;
    logic [33:0] snap;
    int w, acc, lat;
    bit seen;
    exp_bus   = {wr, a, wd, (wr ? st : 4'h0), pr};
    cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_strb = st; cmd_prot = pr;
    cmd_valid = 1'b1;
    ready     = 1'($urandom_range(0, 1));
    #1;
    w = 0;
    while (!cmd_ready && w < 64) begin
      @(negedge clk);
      w++;
    end
    last_wait = w;
    check("accept", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    // A different command held during the transfer must never be taken.
    cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
    check("setup_sel_en", {sel, enable}, 2'b10);
    check("setup_bus", {write, addr, wdata, strb, prot}, exp_bus);
    check("setup_no_rsp", rsp_valid, 0);
    ready = 1'($urandom_range(0, 1)); rdata = $urandom; slave_error = 1'($urandom);
    acc = 0; lat = 1; seen = 1'b0;
    for (int c = 0; c < 64 && !seen; c++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) begin
        seen = 1'b1;
      end else begin
        check("access_sel_en", {sel, enable}, 2'b11);
        check("access_bus", {write, addr, wdata, strb, prot}, exp_bus);
        check("busy_cmd_ready", cmd_ready, 0);
        ready       = (acc == waits);
        rdata       = ready ? srd : $urandom;
        slave_error = ready ? err : 1'($urandom);
        acc++;
      end
    end
    ready = 1'b0; rdata = $urandom; slave_error = 1'($urandom);
    check("rsp_seen", seen, 1);
    check("enable_cycles", acc, e_en);
    check("latency", lat, e_en + 2);
    check("rsp_fields", {rsp_rdata, rsp_error, rsp_timeout}, {e_rdata, e_err, e_to});
    check("rsp_bus_idle", {sel, enable}, 2'b00);
    snap = {rsp_rdata, rsp_error, rsp_timeout};
    for (int d = 0; d < delay; d++) begin
      rsp_ready = 1'b0;
      @(negedge clk);
      check("bp_valid", rsp_valid, 1);
      check("bp_hold", {rsp_rdata, rsp_error, rsp_timeout}, snap);
      check("bp_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_done", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit        wr, err, hit;
    bit [31:0] a, wd, srd, e_rdata;
    bit [3:0]  st;
    bit [2:0]  pr;
    int        waits, delay, e_en;

    //          wr    addr      wdata         strb  prot    wt err srd           dly e_rdata      e_err e_to en
    vecs[0] = '{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 0,  1'b0, 32'hAAAA5555, 0, 32'h0,        1'b0, 1'b0, 1};
    vecs[1] = '{1'b0, 32'h24, 32'h0,        4'hF, 3'b001, 3,  1'b0, 32'h12345678, 0, 32'h12345678, 1'b0, 1'b0, 4};
    vecs[2] = '{1'b1, 32'h30, 32'h01020304, 4'h3, 3'b010, 1,  1'b1, 32'h55555555, 2, 32'h0,        1'b1, 1'b0, 2};
    vecs[3] = '{1'b0, 32'h40, 32'h0,        4'h0, 3'b100, 20, 1'b0, 32'hFFFFFFFF, 1, 32'h0,        1'b1, 1'b1, 8};
    vecs[4] = '{1'b0, 32'h44, 32'h0,        4'h0, 3'b011, 7,  1'b0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 1'b0, 1'b0, 8};
    vecs[5] = '{1'b0, 32'h50, 32'h0,        4'hA, 3'b000, 0,  1'b1, 32'h0BADBEEF, 5, 32'h0BADBEEF, 1'b1, 1'b0, 1};
    vecs[6] = '{1'b1, 32'h54, 32'h87654321, 4'h5, 3'b111, 8,  1'b0, 32'h13579BDF, 0, 32'h0,        1'b1, 1'b1, 8};

    // Reset state, with a command offered during reset.
    rstn = 1'b0;
    cmd_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_apb", {sel, enable, write, addr, wdata, strb, prot}, 0);
    check("rst_rsp", {rsp_valid, rsp_rdata, rsp_error, rsp_timeout}, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    cmd_valid = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {cmd_ready, sel, enable, rsp_valid}, 4'b1000);

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      do_txn(vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].st, vecs[i].pr, vecs[i].waits,
             vecs[i].err, vecs[i].srd, vecs[i].delay, vecs[i].e_rdata, vecs[i].e_err,
             vecs[i].e_to, vecs[i].e_en);
    end

    // Backpressure, then a back-to-back command accepted right after the response handshake.
    do_txn(1'b1, 32'h70, 32'h11112222, 4'hC, 3'b000, 2, 1'b0, 32'h0, 5, 32'h0, 1'b0, 1'b0, 3);
    do_txn(1'b0, 32'h74, 32'h0, 4'hF, 3'b000, 0, 1'b0, 32'h0F0F0F0F, 0,
           32'h0F0F0F0F, 1'b0, 1'b0, 1);
    check("b2b_accept_wait", last_wait, 0);

    // Reset in the middle of ACCESS.
    cmd_write = 1'b0; cmd_addr = 32'h60; cmd_valid = 1'b1; ready = 1'b0;
    for (int c = 0; c < 8 && !cmd_ready; c++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mid_access_en", {sel, enable}, 2'b11);
    rstn = 1'b0;
    @(negedge clk);
    check("mid_rst_apb", {sel, enable, write, addr, wdata, strb, prot}, 0);
    check("mid_rst_rsp", {rsp_valid, cmd_ready}, 0);
    rstn = 1'b1;
    ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("mid_rst_no_rsp", {rsp_valid, sel, cmd_ready}, 3'b001);
    end
    ready = 1'b0;
    do_txn(1'b0, 32'h64, 32'h0, 4'h0, 3'b001, 2, 1'b0, 32'hA5A5A5A5, 1,
           32'hA5A5A5A5, 1'b0, 1'b0, 3);

    // Random traffic against a spec-level model.
    for (int n = 0; n < 30; n++) begin
      wr    = 1'($urandom);
      a     = $urandom;
      wd    = $urandom;
      st    = 4'($urandom);
      pr    = make_prot(1'($urandom), 1'($urandom), 1'($urandom));
      waits = $urandom_range(0, 11);
      err   = 1'($urandom);
      srd   = $urandom;
      delay = $urandom_range(0, 3);
      hit     = (waits >= TO);
      e_en    = hit ? TO : waits + 1;
      e_rdata = (hit || wr) ? 32'h0 : srd;
      do_txn(wr, a, wd, st, pr, waits, err, srd, delay, e_rdata, hit || err, hit, e_en);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
